// File: rtl/booth_pkg.sv
// Shared constants, FSM state encoding and radix-4 Booth digit decoding for
// the iterative Booth partial-product accumulator.
package booth_pkg;

  localparam int BOOTH_ROWS = 8;
  localparam int ROW_W      = 18;
  localparam int PROD_W     = 32;
  localparam int OP_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS1 = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG1 = 3'd3,
    DIG_NEG2 = 3'd4
  } digit_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_t booth_digit(input logic [2:0] win);
    digit_t d;
    case (win)
      3'b001, 3'b010: d = DIG_POS1;
      3'b011:         d = DIG_POS2;
      3'b100:         d = DIG_NEG2;
      3'b101, 3'b110: d = DIG_NEG1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_row_sel.sv
// Combinational Booth row generator: selects 0/a/2a from the digit window and
// negates as needed, producing an 18-bit two's-complement row.
module booth_row_sel
  import booth_pkg::*;
(
  input  logic [OP_W-1:0]  a_i,
  input  logic [2:0]       win_i,
  output logic [ROW_W-1:0] row_o
);

  digit_t           digit_s;
  logic [ROW_W-1:0] a_ext_s;
  logic [ROW_W-1:0] mag_s;
  logic             neg_s;

  assign digit_s = booth_digit(win_i);
  assign a_ext_s = {{(ROW_W-OP_W){a_i[OP_W-1]}}, a_i};

  // Magnitude select and sign of the row.
  always_comb begin
    mag_s = {ROW_W{1'b0}};
    neg_s = 1'b0;
    case (digit_s)
      DIG_POS1: mag_s = a_ext_s;
      DIG_POS2: mag_s = a_ext_s << 1;
      DIG_NEG1: begin
        mag_s = a_ext_s;
        neg_s = 1'b1;
      end
      DIG_NEG2: begin
        mag_s = a_ext_s << 1;
        neg_s = 1'b1;
      end
      default: begin
        mag_s = {ROW_W{1'b0}};
        neg_s = 1'b0;
      end
    endcase
  end

  assign row_o = neg_s ? (~mag_s + 18'd1) : mag_s;

endmodule

// File: rtl/booth_pp_accumulator.sv
// Iterative signed 16x16 radix-4 Booth back end: one partial-product row per
// cycle is shift-aligned into a 32-bit accumulator; low rows may be skipped.
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned APPROX_ROWS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  localparam logic [2:0] IDX_START = 3'(APPROX_ROWS);
  localparam logic [2:0] IDX_LAST  = 3'(BOOTH_ROWS - 1);

  state_t              state_q;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [2:0]          idx_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   product_q;
  logic                out_valid_q;

  logic [OP_W:0]       b_ext_s;
  logic [2:0]          win_s;
  logic [ROW_W-1:0]    row_s;
  logic [PROD_W-1:0]   row_ext_s;
  logic [PROD_W-1:0]   acc_d;

  // Appending a zero below b supplies b[-1]; skipped rows still feed their
  // top bit into the first active row's window.
  assign b_ext_s   = {b_q, 1'b0};
  assign win_s     = b_ext_s[{1'b0, idx_q, 1'b0} +: 3];
  assign row_ext_s = {{(PROD_W-ROW_W){row_s[ROW_W-1]}}, row_s};
  assign acc_d     = acc_q + (row_ext_s << {idx_q, 1'b0});

  booth_row_sel u_row_sel (
    .a_i   (a_q),
    .win_i (win_s),
    .row_o (row_s)
  );

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign out_valid = out_valid_q;
  assign product   = product_q;

  // Control FSM with operand capture, accumulation and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      idx_q       <= 3'd0;
      acc_q       <= 32'd0;
      product_q   <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= 32'd0;
            idx_q   <= IDX_START;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              a_q     <= a;
              b_q     <= b;
              acc_q   <= 32'd0;
              idx_q   <= IDX_START;
              state_q <= ST_CALC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed self-checking bench for booth_pp_accumulator (exact and
// APPROX_ROWS=2 instances), plus a random product sweep with output stalls.
module tb_booth_pp_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b;
  logic [31:0] product;

  logic        in_valid_x, in_ready_x, out_valid_x, out_ready_x;
  logic [15:0] a_x, b_x;
  logic [31:0] product_x;

  int errors;
  int checks;

  booth_pp_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  booth_pp_accumulator #(.APPROX_ROWS(2)) dut_approx (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_x),
    .in_ready  (in_ready_x),
    .a         (a_x),
    .b         (b_x),
    .out_valid (out_valid_x),
    .out_ready (out_ready_x),
    .product   (product_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation with out_ready high; check latency and product.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp, input string tag);
    int n;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_prod"}, product, exp);
    @(negedge clk);
  endtask

  initial begin
    int          n;
    int          stall;
    logic [15:0] ra, rb;
    logic [31:0] sa, sb, exp;

    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = 16'd0;
    b           = 16'd0;
    in_valid_x  = 1'b0;
    out_ready_x = 1'b1;
    a_x         = 16'd0;
    b_x         = 16'd0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", product, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3*5 with cycle-by-cycle latency check.
    in_valid = 1'b1;
    a = 16'd3;
    b = 16'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("calc_in_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("small_early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("small_valid", 32'(out_valid), 32'd1);
    chk("small_prod", product, 32'h0000_000F);
    @(negedge clk);
    chk("small_consumed", 32'(out_valid), 32'd0);
    chk("small_idle_ready", 32'(in_ready), 32'd1);

    run_op(16'hFFFF, 16'h7FFF, 32'hFFFF_8001, "neg1_max");
    run_op(16'h8000, 16'h8000, 32'h4000_0000, "min_min");
    run_op(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "max_max");

    // Backpressure then same-cycle handoff to a new operation.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'd100;
    b = 16'hFFF9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_lat", 32'(n), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_prod", product, 32'hFFFF_FD44);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'd2;
    b = 16'd2;
    #1;
    chk("bypass_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bypass_calc", 32'(in_ready), 32'd0);
    chk("bypass_valid_clr", 32'(out_valid), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bypass_lat", 32'(n), 32'd8);
    chk("bypass_prod", product, 32'd4);
    @(negedge clk);

    // Reset three cycles into CALC.
    in_valid = 1'b1;
    a = 16'd9;
    b = 16'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_prod", product, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd6, 16'd7, 32'd42, "after_rst");

    // Approximate instance, two low rows skipped.
    in_valid_x = 1'b1;
    a_x = 16'h0100;
    b_x = 16'h0013;
    @(posedge clk);
    @(negedge clk);
    in_valid_x = 1'b0;
    n = 0;
    while (!out_valid_x && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("approx_lat", 32'(n), 32'd6);
    chk("approx_prod", product_x, 32'h0000_1000);
    @(negedge clk);

    // Random signed pairs with random output stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      sa = {{16{ra[15]}}, ra};
      sb = {{16{rb[15]}}, rb};
      exp = sa * sb;
      stall = $urandom_range(0, 3);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = ra;
      b = rb;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      repeat (stall) @(negedge clk);
      chk("rand_valid", 32'(out_valid), 32'd1);
      chk("rand_prod", product, exp);
      out_ready = 1'b1;
      @(negedge clk);
      chk("rand_once", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_pp_accumulator.md
# booth_pp_accumulator

Iterative signed 16x16 radix-4 Booth multiplier back end. It sits directly downstream of the partial-product row generators and consumes one 18-bit Booth partial-product row per cycle, shift-aligning and summing the rows into a 32-bit product. A parameter can skip low-order rows, giving an approximate product with shorter latency and lower switching activity.

## Interface
- `APPROX_ROWS`, default 0: number of least-significant Booth rows skipped (legal range 0..7). 0 gives an exact product.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the operand pair on `a`/`b` is valid.
- `in_ready` out 1: the block can accept an operand pair.
- `a` in 16: multiplicand, two's complement.
- `b` in 16: multiplier, two's complement.
- `out_valid` out 1: `product` is valid.
- `out_ready` in 1: the consumer accepts `product`.
- `product` out 32: two's-complement product, registered.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`: capture `a` and `b` into internal registers, clear `acc`, set `idx`=`APPROX_ROWS`, go to CALC.
- **CALC, one row per cycle:**
  - Booth digit d = -2·b[2i+1] + b[2i] + b[2i-1], with b[-1]=0 and i = `idx`.
  - row = d·a, sign-extended to 18 bits. It is produced by the combinational sub-module.
  - `acc` <= `acc` + (sext32(row) << 2i), computed modulo 2^32.
  - `idx` increments each cycle.
  - When `idx`==7: load `product` from the final sum, set `out_valid`=1, go to DONE.
- **DONE:**
  - `product` and `out_valid` are held while `out_ready`=0.
  - On `out_ready`=1, `out_valid` clears.
- **Simultaneous events:**
  - In DONE, `in_ready` = `out_ready` (combinational).
  - `out_ready & in_valid` in the same cycle completes the output and accepts the new operands on the same edge, going straight to CALC.
  - `out_ready` without `in_valid` goes to IDLE.
- **Inputs while busy:** `a`, `b` and `in_valid` are ignored in CALC. Only the captured copies are used.
- **Width rule:** the exact signed 16x16 product always fits in 32 bits, including -32768·-32768 = 0x4000_0000. No overflow handling.
- **Approximation:**
  - Rows 0..`APPROX_ROWS`-1 contribute 0.
  - Row `APPROX_ROWS` still uses b[2·`APPROX_ROWS`-1] as its b[i-1] bit.
- **Reset (asynchronous, any state, including mid-CALC):**
  - State goes to IDLE; `acc`, `idx`, `product` go to 0; `out_valid` goes to 0.
  - `in_ready` reads 1, since it is derived from IDLE.
  - An in-flight operation is discarded, with no partial output.

## Timing
- **Latency:** accept edge E. Rows are processed on edges E+1 .. E+(8-`APPROX_ROWS`). `out_valid` is high from the cycle after edge E+8-`APPROX_ROWS`, i.e. 8 cycles for `APPROX_ROWS`=0.
- **Throughput:**
  - With `out_ready` tied high: one result per 9-`APPROX_ROWS` cycles, using the DONE-to-CALC bypass.
  - Otherwise one result per 10-`APPROX_ROWS` cycles.
- **Registered outputs:** `product` and `out_valid`.
- **Combinational outputs:** `in_ready` is a function of state and `out_ready` only. There is no path from `a`/`b` to any output.

## Structure
- **Shared package `booth_pkg`:**
  - `BOOTH_ROWS`=8, `ROW_W`=18, `PROD_W`=32.
  - FSM state encoding (IDLE, CALC, DONE).
  - Booth digit encoding constants (0, +1, +2, -1, -2).
- **Sub-module `booth_row_sel`:**
  - Combinational; inputs `a`[15:0] and a 3-bit digit window; output an 18-bit signed row.
  - Implements the select / shift / negate.
  - It is instantiated once and time-multiplexed across rows.
- **Top-level contents:** FSM, operand capture registers, 3-bit `idx` counter, 32-bit accumulator, output register.

## Test plan
- **Exact small product:** a=3, b=5 with `out_ready`=1 → `out_valid` exactly 8 cycles after accept, `product`=0x0000_000F; `in_ready` low during CALC.
- **Sign and extremes:**
  - a=-1, b=32767 → 0xFFFF_8001.
  - a=-32768, b=-32768 → 0x4000_0000.
  - a=0x7FFF, b=0x7FFF → 0x3FFF_0001.
- **Backpressure:** a=100, b=-7; hold `out_ready`=0 for 5 cycles → `product`=0xFFFF_FD44 stable, `out_valid` held; then `out_ready`=1 with new `in_valid` (a=2, b=2) → accepted the same cycle, next `product`=4 after 8 cycles.
- **Reset mid-operation:** deassert `rst_n` 3 cycles into CALC → `out_valid`=0, `product`=0, `in_ready`=1 immediately; the next operation (a=6, b=7) returns 42 with normal latency.
- **Approximate mode:** `APPROX_ROWS`=2, a=0x0100, b=0x0013 → `product`=0x0000_1000 (exact would be 0x1300), latency 6 cycles.
- **Randomized check:** 1000 random signed pairs with random `out_ready` stalls at `APPROX_ROWS`=0 → every `product` equals a·b; no result lost or duplicated.
